// File: rtl/me0_address_t.sv
// Load/store address-phase stage (ME0) for the ldst1 AHB-Lite master port.
// Registers EX ops, drives the AHB address phase, and feeds the ME1 data-phase registers.
module me0_address_t #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  output logic        ex_ready,
  input  logic        me1_memhaz,
  input  logic        ldst1_ahb_HREADY,
  input  logic        ldst1_ahb_HRESP,
  output logic [31:0] ldst1_ahb_HADDR,
  output logic [1:0]  ldst1_ahb_HTRANS,
  output logic        ldst1_ahb_HWRITE,
  output logic [2:0]  ldst1_ahb_HSIZE,
  output logic [2:0]  ldst1_ahb_HBURST,
  output logic [3:0]  ldst1_ahb_HPROT,
  output logic [1:0]  r_me1_alu_Q,
  output logic [3:0]  r_me1_memop_Q,
  output logic [31:0] r_me1_wtdat_Q,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic is_store(input logic [3:0] m);
    return (m == 4'h1) || (m == 4'h2) || (m == 4'h3);
  endfunction

  function automatic logic is_legal(input logic [3:0] m);
    return is_store(m) || ((m >= 4'h9) && (m <= 4'hd));
  endfunction

  function automatic logic [2:0] size_of(input logic [3:0] m);
    case (m)
      4'h2, 4'hb, 4'hc: size_of = 3'd1;
      4'h3, 4'hd:       size_of = 3'd2;
      default:          size_of = 3'd0;
    endcase
  endfunction

  logic        me0_valid_q, me0_valid_d;
  logic [3:0]  me0_memop_q, me0_memop_d;
  logic [31:0] me0_addr_q,  me0_addr_d;
  logic [31:0] me0_wdata_q, me0_wdata_d;
  logic        me0_misal_q, me0_misal_d;

  logic [3:0]  me1_memop_q, me1_memop_d;
  logic [1:0]  me1_alu_q,   me1_alu_d;
  logic [31:0] me1_wtdat_q, me1_wtdat_d;
  logic [31:0] me1_addr_q,  me1_addr_d;

  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q,  exc_addr_d;

  logic        advance;
  logic        take;
  logic [2:0]  ex_size;
  logic        bus_err;
  logic        mis_exc;

  always_comb begin
    advance = !me1_memhaz && !RST;
    take    = ex_valid && !flush && is_legal(ex_memop);
    ex_size = size_of(ex_memop);

    me0_valid_d = me0_valid_q;
    me0_memop_d = me0_memop_q;
    me0_addr_d  = me0_addr_q;
    me0_wdata_d = me0_wdata_q;
    me0_misal_d = me0_misal_q;
    me1_memop_d = me1_memop_q;
    me1_alu_d   = me1_alu_q;
    me1_wtdat_d = me1_wtdat_q;
    me1_addr_d  = me1_addr_q;

    if (advance) begin
      // Bubbles are all-zero so they flow into ME1 as memop 0 with clean data.
      me0_valid_d = take;
      me0_memop_d = take ? ex_memop : 4'h0;
      me0_addr_d  = take ? ex_addr  : 32'h0;
      me0_wdata_d = (take && is_store(ex_memop)) ? (ex_wdata << {ex_addr[1:0], 3'b000}) : 32'h0;
      me0_misal_d = take && (((ex_size == 3'd1) && ex_addr[0]) ||
                             ((ex_size == 3'd2) && (ex_addr[1:0] != 2'b00)));

      me1_memop_d = (me0_valid_q && !me0_misal_q) ? me0_memop_q : 4'h0;
      me1_alu_d   = me0_addr_q[1:0];
      me1_wtdat_d = me0_wdata_q;
      me1_addr_d  = me0_addr_q;
    end

    // Bus error on the data phase outranks a misalignment from the younger op.
    bus_err     = (me1_memop_q != 4'h0) && ldst1_ahb_HRESP;
    mis_exc     = advance && me0_valid_q && me0_misal_q;
    exc_valid_d = bus_err || mis_exc;
    exc_cause_d = 2'd0;
    exc_addr_d  = 32'h0;
    if (bus_err) begin
      exc_cause_d = 2'd3;
      exc_addr_d  = me1_addr_q;
    end else if (mis_exc) begin
      exc_cause_d = is_store(me0_memop_q) ? 2'd2 : 2'd1;
      exc_addr_d  = me0_addr_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      me0_valid_q <= 1'b0;
      me0_memop_q <= 4'h0;
      me0_addr_q  <= 32'h0;
      me0_wdata_q <= 32'h0;
      me0_misal_q <= 1'b0;
      me1_memop_q <= 4'h0;
      me1_alu_q   <= 2'b00;
      me1_wtdat_q <= 32'h0;
      me1_addr_q  <= 32'h0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 2'd0;
      exc_addr_q  <= 32'h0;
    end else begin
      me0_valid_q <= me0_valid_d;
      me0_memop_q <= me0_memop_d;
      me0_addr_q  <= me0_addr_d;
      me0_wdata_q <= me0_wdata_d;
      me0_misal_q <= me0_misal_d;
      me1_memop_q <= me1_memop_d;
      me1_alu_q   <= me1_alu_d;
      me1_wtdat_q <= me1_wtdat_d;
      me1_addr_q  <= me1_addr_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  // Wait states are carried by me1_memhaz, so HREADY is not consulted here.
  logic unused_hready;
  assign unused_hready = ldst1_ahb_HREADY;

  assign ex_ready         = advance;
  assign ldst1_ahb_HTRANS = (me0_valid_q && !me0_misal_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ldst1_ahb_HADDR  = me0_valid_q ? me0_addr_q : RESET_ADDR;
  assign ldst1_ahb_HWRITE = is_store(me0_memop_q);
  assign ldst1_ahb_HSIZE  = size_of(me0_memop_q);
  assign ldst1_ahb_HBURST = 3'b000;
  assign ldst1_ahb_HPROT  = 4'b0011;
  assign r_me1_alu_Q      = me1_alu_q;
  assign r_me1_memop_Q    = me1_memop_q;
  assign r_me1_wtdat_Q    = me1_wtdat_q;
  assign exc_valid        = exc_valid_q;
  assign exc_cause        = exc_cause_q;
  assign exc_addr         = exc_addr_q;

endmodule
